dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-ported 64-bit data memory with a valid/ready request and
// response handshake, one outstanding access and a one-cycle response latency.
// Supports byte/half/word/dword loads (sign- or zero-extended) and byte-masked
// stores.
// Build option: define DMEM_ERR_EN to fault misaligned and out-of-range
// accesses (resp_err = 1, no write). Without it, addresses wrap modulo the
// array size and offsets are forced to the access alignment.
//
// state | meaning
// IDLE  | no response pending, ready for a request
// RESP  | response presented, waiting for resp_ready
module dmem_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_wdt,
  input  logic        req_sext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t state, state_nxt;

  logic [63:0] mem [DEPTH];

  logic                  accept;
  logic [63:0]           diff;
  logic [DEPTH_LOG2-1:0] idx;
  logic [2:0]            off;
  logic [2:0]            size_mask;
  logic [2:0]            off_eff;
  logic                  fault;
  logic [7:0]            base_en;
  logic [7:0]            byte_en;
  logic [63:0]           wdata_sh;

  logic [63:0] word_q;
  logic [2:0]  off_q;
  logic [1:0]  wdt_q;
  logic        sext_q;
  logic        load_q;
  logic        err_q;
  logic [63:0] lane;
  logic [63:0] rdata;

  assign accept = req_valid & req_ready;
  assign diff   = req_addr - BASE_ADDR;
  assign idx    = diff[DEPTH_LOG2+2:3];
  assign off    = req_addr[2:0];

  // access size decode: offset alignment mask and unshifted byte enables
  always_comb begin
    size_mask = 3'b000;
    base_en   = 8'h01;
    case (req_wdt)
      2'b00: begin size_mask = 3'b000; base_en = 8'h01; end
      2'b01: begin size_mask = 3'b001; base_en = 8'h03; end
      2'b10: begin size_mask = 3'b011; base_en = 8'h0F; end
      default: begin size_mask = 3'b111; base_en = 8'hFF; end
    endcase
  end

`ifdef DMEM_ERR_EN
  // addresses below BASE_ADDR wrap to a huge difference and land in the range fault
  assign off_eff = off;
  assign fault   = ((off & size_mask) != 3'b000) |
                   ((diff >> (DEPTH_LOG2 + 3)) != 64'd0);
`else
  logic unused_diff;
  assign off_eff     = off & ~size_mask;
  assign fault       = 1'b0;
  assign unused_diff = ^{diff[63:DEPTH_LOG2+3], diff[2:0]};
`endif

  assign byte_en  = base_en << off_eff;
  assign wdata_sh = req_wdata << {off_eff, 3'b000};

  // array write on an accepted, non-faulting store; reset suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && accept && req_wen && !fault) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // capture the addressed word and access attributes at accept; held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= 64'd0;
      off_q  <= 3'd0;
      wdt_q  <= 2'd0;
      sext_q <= 1'b0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      word_q <= mem[idx];
      off_q  <= off_eff;
      wdt_q  <= req_wdt;
      sext_q <= req_sext;
      load_q <= ~req_wen & ~fault;
      err_q  <= fault;
    end
  end

  // lane extraction and extension from the captured word
  always_comb begin
    lane  = word_q >> {off_q, 3'b000};
    rdata = 64'd0;
    if (load_q) begin
      case (wdt_q)
        2'b00:   rdata = sext_q ? {{56{lane[7]}},  lane[7:0]}  : {56'd0, lane[7:0]};
        2'b01:   rdata = sext_q ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
        2'b10:   rdata = sext_q ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
        default: rdata = lane;
      endcase
    end
  end

  assign resp_rdata = rdata;
  assign resp_err   = err_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: an accept always (re)enters RESP, a bare consume returns to IDLE
  always_comb begin
    state_nxt = state;
    if (accept)                           state_nxt = RESP;
    else if (state == RESP && resp_ready) state_nxt = IDLE;
  end

  // handshake outputs
  always_comb begin
    resp_valid = (state == RESP);
    req_ready  = (state == IDLE) | ((state == RESP) & resp_ready);
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed requests with hand-computed responses,
// checked by a scoreboard monitor on each response handshake.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_wdt;
  logic        req_sext;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wdt    (req_wdt),
    .req_sext   (req_sext),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   seen_cyc = 0;
  bit   pending_seen = 1'b0;

`ifdef DMEM_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // monitor: note when each response first appears, compare on handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pending_seen = 1'b0;
    end else if (resp_valid) begin
      if (!pending_seen) begin
        pending_seen = 1'b1;
        seen_cyc     = cyc;
      end
      if (resp_ready) begin
        pending_seen = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h err %b with no request pending",
                   resp_rdata, resp_err);
        end else begin
          e = sb.pop_front();
          check64({e.name, "_rdata"}, resp_rdata, e.rdata);
          check1({e.name, "_err"}, resp_err, e.err);
          check64({e.name, "_latency"}, 64'(seen_cyc - e.acc_cyc), 64'd1);
        end
      end
    end
  end

  task automatic push_exp(string nm, logic [63:0] rd, logic er);
    exp_t e;
    e.rdata   = rd;
    e.err     = er;
    e.acc_cyc = cyc;
    e.name    = nm;
    sb.push_back(e);
  endtask

  // present one request, wait for acceptance, record its expected response
  task automatic do_req(string nm, logic wen, logic [63:0] addr, logic [63:0] wdata,
                        logic [1:0] wdt, logic sext, logic [63:0] exp_rd, logic exp_err);
    int n = 0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wdt   = wdt;
    req_sext  = sext;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: req_ready %b expected 1", nm, req_ready);
    end else begin
      push_exp(nm, exp_rd, exp_err);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w0_final;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    req_wdt    = 2'b00;
    req_sext   = 1'b0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check64("rst_resp_rdata", resp_rdata, 64'd0);
    check1("rst_resp_err", resp_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("req_ready_after_rst", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // dword store then sub-word loads of word 0
    do_req("st_dw0",   1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, 2'b11, 1'b0, 64'd0, 1'b0);
    do_req("ld_w4_s",  1'b0, 64'h8000_0004, 64'd0, 2'b10, 1'b1, 64'h0000_0000_1122_3344, 1'b0);
    do_req("ld_w0_s",  1'b0, 64'h8000_0000, 64'd0, 2'b10, 1'b1, 64'h0000_0000_5566_7788, 1'b0);
    do_req("ld_h6_s",  1'b0, 64'h8000_0006, 64'd0, 2'b01, 1'b1, 64'h0000_0000_0000_1122, 1'b0);
    do_req("ld_b7_z",  1'b0, 64'h8000_0007, 64'd0, 2'b00, 1'b0, 64'h0000_0000_0000_0011, 1'b0);
    do_req("ld_h2_s",  1'b0, 64'h8000_0002, 64'd0, 2'b01, 1'b1, 64'h0000_0000_0000_5566, 1'b0);

    // byte store with back-to-back read-after-write
    do_req("st_b3",    1'b1, 64'h8000_0003, 64'h0000_0000_0000_0080, 2'b00, 1'b0, 64'd0, 1'b0);
    do_req("ld_b3_s",  1'b0, 64'h8000_0003, 64'd0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    do_req("ld_b3_z",  1'b0, 64'h8000_0003, 64'd0, 2'b00, 1'b0, 64'h0000_0000_0000_0080, 1'b0);
    do_req("ld_w0_z",  1'b0, 64'h8000_0000, 64'd0, 2'b10, 1'b0, 64'h0000_0000_8066_7788, 1'b0);
    do_req("ld_w0_s2", 1'b0, 64'h8000_0000, 64'd0, 2'b10, 1'b1, 64'hFFFF_FFFF_8066_7788, 1'b0);

    // half store into upper half of word 1; wdata upper bits must be ignored
    do_req("st_dw1",   1'b1, 64'h8000_0008, 64'd0, 2'b11, 1'b0, 64'd0, 1'b0);
    do_req("st_hC",    1'b1, 64'h8000_000C, 64'hAAAA_AAAA_AAAA_BEEF, 2'b01, 1'b0, 64'd0, 1'b0);
    do_req("ld_dw1",   1'b0, 64'h8000_0008, 64'd0, 2'b11, 1'b1, 64'h0000_BEEF_0000_0000, 1'b0);
    do_req("ld_hC_s",  1'b0, 64'h8000_000C, 64'd0, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
    do_req("ld_hC_z",  1'b0, 64'h8000_000C, 64'd0, 2'b01, 1'b0, 64'h0000_0000_0000_BEEF, 1'b0);
    drain();

    // response backpressure with a waiting request
    resp_ready = 1'b0;
    do_req("bp_a", 1'b0, 64'h8000_0000, 64'd0, 2'b11, 1'b0, 64'h1122_3344_8066_7788, 1'b0);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 64'h8000_0004;
    req_wdt   = 2'b10;
    req_sext  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("bp_resp_valid", resp_valid, 1'b1);
      check64("bp_resp_rdata", resp_rdata, 64'h1122_3344_8066_7788);
      check1("bp_req_ready", req_ready, 1'b0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_ready", req_ready, 1'b1);
    push_exp("bp_b", 64'h0000_0000_1122_3344, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();

    if (ERR_BUILD) begin
      do_req("err_mis_h1", 1'b0, 64'h8000_0001, 64'd0, 2'b01, 1'b1, 64'd0, 1'b1);
      do_req("err_st_oor", 1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11, 1'b0, 64'd0, 1'b1);
      do_req("err_ld_w0",  1'b0, 64'h8000_0000, 64'd0, 2'b11, 1'b0, 64'h1122_3344_8066_7788, 1'b0);
      do_req("err_below",  1'b0, 64'h7FFF_FFF8, 64'd0, 2'b10, 1'b0, 64'd0, 1'b1);
      w0_final = 64'h1122_3344_8066_7788;
    end else begin
      do_req("wrap_st",    1'b1, 64'h8000_2000, 64'hCAFE_F00D_1234_5678, 2'b11, 1'b0, 64'd0, 1'b0);
      do_req("wrap_ld_w0", 1'b0, 64'h8000_0000, 64'd0, 2'b11, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0);
      do_req("align_h1",   1'b0, 64'h8000_0001, 64'd0, 2'b01, 1'b1, 64'h0000_0000_0000_5678, 1'b0);
      do_req("align_w6",   1'b0, 64'h8000_0006, 64'd0, 2'b10, 1'b1, 64'hFFFF_FFFF_CAFE_F00D, 1'b0);
      w0_final = 64'hCAFE_F00D_1234_5678;
    end
    drain();

    // reset mid-response; a store presented during reset must not land
    resp_ready = 1'b0;
    do_req("rst_ld", 1'b0, 64'h8000_0008, 64'd0, 2'b11, 1'b0, 64'h0000_BEEF_0000_0000, 1'b0);
    @(negedge clk);
    check1("pre_rst_valid", resp_valid, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check1("mid_rst_resp_valid", resp_valid, 1'b0);
    check64("mid_rst_resp_rdata", resp_rdata, 64'd0);
    check1("mid_rst_resp_err", resp_err, 1'b0);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 64'h8000_0000;
    req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
    req_wdt   = 2'b11;
    @(negedge clk);
    check1("rst_idle_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    rst        = 1'b0;
    resp_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check1("post_rst_ready", req_ready, 1'b1);
    check1("post_rst_valid", resp_valid, 1'b0);
    @(posedge clk);
    #1;
    do_req("post_rst_w0", 1'b0, 64'h8000_0000, 64'd0, 2'b11, 1'b0, w0_final, 1'b0);
    do_req("post_rst_w1", 1'b0, 64'h8000_0008, 64'd0, 2'b11, 1'b0, 64'h0000_BEEF_0000_0000, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
